uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
- Parametrised full-duplex UART core: the next-generation transceiver behind the TT03 top-level wrapper.
- Adds over the fixed-format design:
  - runtime baud divisor
  - configurable data width, stop bits and parity
  - oversampled RX with false-start rejection
  - first-word-fall-through (FWFT) RX FIFO
  - sticky error flags
- Sits between the io_in/io_out pin mapping and user logic.
- Valid/ready handshakes on both byte streams.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..8.
- OVERSAMPLE, 16: ticks per bit, even, legal 8..32.
- DIV_W, 12: width of baud_div.
- STOP_BITS, 1: TX stop bits, 1 or 2. RX always checks one.
- FIFO_DEPTH, 4: RX FIFO entries, power of two, 2..16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- baud_div  in  DIV_W  prescaler; tick every baud_div+1 clocks
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  core accepts tx_data this cycle
- tx_busy  out  1  frame in progress on txd
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, asynchronous
- rx_data  out  DATA_BITS  FIFO head
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  pop FIFO head
- rx_parity_err  out  1  sticky
- rx_frame_err  out  1  sticky
- rx_overrun  out  1  sticky
- err_clr  in  1  clears all three sticky flags

Behaviour:
- Reset (rst_n low at a clk edge): every register cleared.
  - Outputs: txd=1, tx_busy=0, tx_ready=1, rx_valid=0, rx_data=0, all error flags 0.
  - FIFO empty; both FSMs return to IDLE.
  - Reset mid-frame abandons the frame: txd=1 on the next edge.
- baud_div and parity_mode are sampled only when a frame starts; changes mid-frame do not affect that frame.
- TX:
  - Separate prescaler, held at 0 while in IDLE.
  - Handshake fires on tx_valid & tx_ready. tx_ready = (tx_state==IDLE), so it stays low for the whole frame. tx_data is latched on the handshake.
  - FSM: IDLE -> START -> DATA (LSB first, DATA_BITS bits) -> PARITY (skipped if none) -> STOP (STOP_BITS bits) -> IDLE.
  - txd changes on the clock after the handshake.
  - Each bit lasts exactly OVERSAMPLE*(baud_div+1) clocks.
  - Parity bit: even = XOR of data bits; odd = its inverse.
  - tx_busy = !IDLE. The next frame may begin the cycle after returning to IDLE: back-to-back, no gap.
- RX synchroniser and prescaler:
  - rxd passes through a 2-FF synchroniser (rxs) before any use.
  - Own prescaler and tick counter, both reset on start-edge detection.
- RX FSM:
  - IDLE: a falling edge on rxs -> START.
  - START: at tick OVERSAMPLE/2, if rxs==1 this is a false start: -> IDLE, no flag. Otherwise -> DATA.
  - DATA: sample once at each bit centre (every OVERSAMPLE ticks), LSB first.
  - PARITY: compare the sampled bit; a mismatch marks the word parity-bad.
  - STOP: sample at the centre, then go to IDLE immediately so the receiver can resync to the next start edge.
- RX word handling at the stop sample:
  - Stop=0: word discarded, rx_frame_err set.
  - Stop=1: word pushed to the FIFO; rx_parity_err set if parity-bad.
  - FIFO full at push and no pop in the same cycle: word dropped, rx_overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no overrun.
- FIFO:
  - FWFT: rx_data is valid whenever rx_valid=1.
  - rx_ready while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; the count register is FIFO_DEPTH+1 states wide.
  - Pushed word is visible on rx_valid/rx_data the next cycle.
- Sticky flags: set on event, cleared by err_clr. If set and clear occur in the same cycle, set wins.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When 1: the RX synchroniser input is the internal TX serial line instead of rxd, and the txd pin is forced to 1.
  - loopback is sampled per clock.
- Undefined:
  - Port absent; RX always uses rxd.

Test Plan:
1. OVERSAMPLE=16, baud_div=0, parity none, send 0xA5 -> txd low 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, then high 16 clk. tx_ready high again 160 clk after the handshake.
2. txd looped to rxd, parity even, send 0x3C then 0xC3 back-to-back -> rx_data 0x3C then 0xC3, each with rx_valid. TX parity bits 0 and 0. No error flags.
3. Drive a frame for 0x01 with even parity and parity bit 0 -> 0x01 pushed, rx_parity_err=1. Assert err_clr for 1 cycle -> flag 0.
4. Drive 0x55 with stop bit 0 -> no push, rx_valid stays 0, rx_frame_err=1.
5. FIFO_DEPTH=4, rx_ready=0, receive 0x10..0x14 -> FIFO holds 0x10..0x13 in order, rx_overrun=1. Pop 4 words -> rx_valid=0.
6. rxd low pulse of 4 clk at baud_div=0 -> no push, no flags. Separately, rst_n low for 1 clk mid-TX -> txd=1 and tx_ready=1 on the next edge.

Source files
------------

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART (runtime divisor, parity, 1/2 stop bits) with an FWFT RX FIFO.
// Latency: txd moves on the clock after the tx handshake; a received word shows on rx_valid the clock after its stop sample.
// Backpressure: tx_ready is low for the whole frame; RX words are dropped (rx_overrun) when the FIFO is full and not popped.
// Optional feature macro UART_LOOPBACK_EN: adds a loopback input that routes the TX line into the RX synchroniser.

// Generic FWFT FIFO: head is presented on pop_dat whenever pop_vld is high.
// Latency: a pushed word is visible on pop_vld/pop_dat one clock later.
// Backpressure: push_rdy drops when full, unless a pop happens in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push, pop;

    assign pop_vld  = (cnt_q != '0);
    assign pop_dat  = mem_q[rd_ptr_q];
    assign pop      = pop_rdy && pop_vld;
    assign push_rdy = (cnt_q != FULL_CNT) || pop;
    assign push     = push_vld && push_rdy;

    // Next-state for storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module uart_core_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 12,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 txd,
    input  logic                 rxd,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic                 err_clr
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // ---------------- TX ----------------
    logic [2:0]           tx_state_q, tx_state_d;
    logic [DIV_W-1:0]     tx_div_q, tx_div_d, tx_pre_q, tx_pre_d;
    logic [TW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_tick, tx_bit_end, rx_in;

    assign tx_ready   = (tx_state_q == ST_IDLE);
    assign tx_busy    = !tx_ready;
    assign tx_tick    = !tx_ready && (tx_pre_q == tx_div_q);
    assign tx_bit_end = tx_tick && (tx_cnt_q == TICK_LAST);

`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_line_q : rxd;
    assign txd   = loopback ? 1'b1 : tx_line_q;
`else
    assign rx_in = rxd;
    assign txd   = tx_line_q;
`endif

    // TX frame sequencer: format and divisor are captured at the handshake.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_div_d    = tx_div_q;
        tx_pre_d    = '0;
        tx_cnt_d    = '0;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_en_d = tx_par_en_q;
        tx_par_d    = tx_par_q;
        tx_line_d   = tx_line_q;
        if (!tx_ready) begin
            tx_pre_d = tx_tick ? '0 : tx_pre_q + 1'b1;
            tx_cnt_d = tx_tick ? (tx_bit_end ? '0 : tx_cnt_q + 1'b1) : tx_cnt_q;
        end
        case (tx_state_q)
            ST_IDLE: if (tx_valid) begin
                tx_state_d  = ST_START;
                tx_div_d    = baud_div;
                tx_shift_d  = tx_data;
                tx_par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                tx_par_d    = (^tx_data) ^ (parity_mode == 2'b10);
                tx_bit_d    = '0;
                tx_line_d   = 1'b0;
            end
            ST_START: if (tx_bit_end) begin
                tx_state_d = ST_DATA;
                tx_line_d  = tx_shift_q[0];
                tx_shift_d = tx_shift_q >> 1;
            end
            ST_DATA: if (tx_bit_end) begin
                if (tx_bit_q == DATA_LAST) begin
                    tx_bit_d   = '0;
                    tx_state_d = tx_par_en_q ? ST_PAR : ST_STOP;
                    tx_line_d  = tx_par_en_q ? tx_par_q : 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end
            end
            ST_PAR: if (tx_bit_end) begin
                tx_state_d = ST_STOP;
                tx_line_d  = 1'b1;
            end
            ST_STOP: if (tx_bit_end) begin
                if (tx_bit_q == STOP_LAST) tx_state_d = ST_IDLE;
                else                       tx_bit_d   = tx_bit_q + 1'b1;
            end
            default: begin
                tx_state_d = ST_IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // TX registers; the line idles high, so reset drives it high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q  <= ST_IDLE;
            tx_div_q    <= '0;
            tx_pre_q    <= '0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
            tx_line_q   <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_div_q    <= tx_div_d;
            tx_pre_q    <= tx_pre_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_en_q <= tx_par_en_d;
            tx_par_q    <= tx_par_d;
            tx_line_q   <= tx_line_d;
        end
    end

    // ---------------- RX ----------------
    logic                 rx_meta_q, rx_meta_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
    logic [2:0]           rx_state_q, rx_state_d;
    logic [DIV_W-1:0]     rx_div_q, rx_div_d, rx_pre_q, rx_pre_d;
    logic [TW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
    logic                 rx_acc_q, rx_acc_d, rx_bad_q, rx_bad_d;
    logic                 rx_tick, rx_sample, rx_push, push_rdy;
    logic                 par_set, frame_set, ovr_set;
    logic                 par_err_q, par_err_d, frame_err_q, frame_err_d, ovr_q, ovr_d;

    assign rx_tick   = (rx_state_q != ST_IDLE) && (rx_pre_q == rx_div_q);
    // Start bit is checked half a bit in; every later sample lands a full bit later, i.e. at bit centres.
    assign rx_sample = rx_tick && (rx_cnt_q == ((rx_state_q == ST_START) ? HALF_LAST : TICK_LAST));

    // RX synchroniser, timing and frame decoding.
    always_comb begin
        rx_meta_d   = rx_in;
        rxs_d       = rx_meta_q;
        rxs_prev_d  = rxs_q;
        rx_state_d  = rx_state_q;
        rx_div_d    = rx_div_q;
        rx_pre_d    = '0;
        rx_cnt_d    = '0;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_en_d = rx_par_en_q;
        rx_odd_d    = rx_odd_q;
        rx_acc_d    = rx_acc_q;
        rx_bad_d    = rx_bad_q;
        rx_push     = 1'b0;
        par_set     = 1'b0;
        frame_set   = 1'b0;
        if (rx_state_q != ST_IDLE) begin
            rx_pre_d = rx_tick ? '0 : rx_pre_q + 1'b1;
            rx_cnt_d = rx_tick ? (rx_sample ? '0 : rx_cnt_q + 1'b1) : rx_cnt_q;
        end
        case (rx_state_q)
            ST_IDLE: if (rxs_prev_q && !rxs_q) begin
                rx_state_d  = ST_START;
                rx_div_d    = baud_div;
                rx_par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                rx_odd_d    = (parity_mode == 2'b10);
                rx_acc_d    = 1'b0;
                rx_bad_d    = 1'b0;
                rx_bit_d    = '0;
            end
            ST_START: if (rx_sample) rx_state_d = rxs_q ? ST_IDLE : ST_DATA;
            ST_DATA: if (rx_sample) begin
                rx_shift_d = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
                rx_acc_d   = rx_acc_q ^ rxs_q;
                if (rx_bit_q == DATA_LAST) begin
                    rx_bit_d   = '0;
                    rx_state_d = rx_par_en_q ? ST_PAR : ST_STOP;
                end else begin
                    rx_bit_d = rx_bit_q + 1'b1;
                end
            end
            ST_PAR: if (rx_sample) begin
                rx_bad_d   = rx_acc_q ^ rxs_q ^ rx_odd_q;
                rx_state_d = ST_STOP;
            end
            ST_STOP: if (rx_sample) begin
                rx_state_d = ST_IDLE;
                rx_push    = rxs_q;
                par_set    = rxs_q && rx_bad_q;
                frame_set  = !rxs_q;
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // RX registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b0;
            rxs_q       <= 1'b0;
            rxs_prev_q  <= 1'b0;
            rx_state_q  <= ST_IDLE;
            rx_div_q    <= '0;
            rx_pre_q    <= '0;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_en_q <= 1'b0;
            rx_odd_q    <= 1'b0;
            rx_acc_q    <= 1'b0;
            rx_bad_q    <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rxs_q       <= rxs_d;
            rxs_prev_q  <= rxs_prev_d;
            rx_state_q  <= rx_state_d;
            rx_div_q    <= rx_div_d;
            rx_pre_q    <= rx_pre_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_en_q <= rx_par_en_d;
            rx_odd_q    <= rx_odd_d;
            rx_acc_q    <= rx_acc_d;
            rx_bad_q    <= rx_bad_d;
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rx_push),
        .push_rdy (push_rdy),
        .push_dat (rx_shift_q),
        .pop_vld  (rx_valid),
        .pop_rdy  (rx_ready),
        .pop_dat  (rx_data)
    );

    assign ovr_set = rx_push && !push_rdy;

    // Sticky error flags: a set in the same cycle as err_clr wins.
    always_comb begin
        par_err_d   = par_set   || (par_err_q   && !err_clr);
        frame_err_d = frame_set || (frame_err_q && !err_clr);
        ovr_d       = ovr_set   || (ovr_q       && !err_clr);
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rx_parity_err = par_err_q;
    assign rx_frame_err  = frame_err_q;
    assign rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: TX framing/timing, loopback RX, error flags, FIFO overrun, false start, reset.
// All inputs change and all outputs are sampled on the falling clock edge.
// Expected values are hand-computed frame bit patterns and constants.
module tb_uart_core_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] baud_div;
    logic [1:0]  parity_mode;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_busy, txd;
    logic        rxd, rxd_drv, lb_sel;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic        rx_parity_err, rx_frame_err, rx_overrun, err_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rxd = lb_sel ? txd : rxd_drv;

    uart_core_param dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_div      (baud_div),
        .parity_mode   (parity_mode),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_busy       (tx_busy),
        .txd           (txd),
        .rxd           (rxd),
`ifdef UART_LOOPBACK_EN
        .loopback      (1'b0),
`endif
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .err_clr       (err_clr)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_word();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic clr_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Drive a serial frame on rxd at 16 clocks per bit, bit 0 first, then idle high.
    task automatic drive_frame(input logic [11:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rxd_drv = bits[i];
            repeat (16) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    logic [9:0]  frame;
    logic [15:0] obs16;
    logic        rdy_last, par1, par2;
    int          cnt;

    initial begin
        rst_n = 1'b0; baud_div = '0; parity_mode = 2'b00; tx_data = '0; tx_valid = 1'b0;
        rx_ready = 1'b0; err_clr = 1'b0; rxd_drv = 1'b1; lb_sel = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk_eq("rst_txd", txd, 1);
        chk_eq("rst_busy", tx_busy, 0);
        chk_eq("rst_ready", tx_ready, 1);
        chk_eq("rst_rx_valid", rx_valid, 0);
        chk_eq("rst_rx_data", rx_data, 0);
        chk_eq("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);

        // 1: 0xA5, no parity, divisor 0 -> start, 1,0,1,0,0,1,0,1, stop, 16 clocks each
        frame = {1'b1, 8'hA5, 1'b0};
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk_eq("t1_busy", tx_busy, 1);
        chk_eq("t1_ready_low", tx_ready, 0);
        rdy_last = 1'b1;
        for (int b = 0; b < 10; b++) begin
            obs16 = '0;
            for (int k = 0; k < 16; k++) begin
                obs16[k] = txd;
                if (b == 9 && k == 15) rdy_last = tx_ready;
                @(negedge clk);
            end
            chk_eq($sformatf("t1_bit%0d", b), obs16, {16{frame[b]}});
        end
        chk_eq("t1_ready_159", rdy_last, 0);
        chk_eq("t1_ready_160", tx_ready, 1);
        chk_eq("t1_idle_busy", tx_busy, 0);

        // 1b: divisor 2 latched at the handshake; changing it mid-frame has no effect
        baud_div = 12'd2; tx_data = 8'h5A; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; baud_div = '0;
        cnt = 0;
        while (!tx_ready && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        chk_eq("t1b_frame_len", cnt, 480);

        // 2: external loopback, even parity, 0x3C then 0xC3 back-to-back
        lb_sel = 1'b1; parity_mode = 2'b01;
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hC3;
        cnt = 0; par1 = 1'b1;
        while (!tx_ready && cnt < 1000) begin
            if (cnt == 152) par1 = txd;
            @(negedge clk);
            cnt++;
        end
        chk_eq("t2_len1", cnt, 176);
        @(negedge clk);
        tx_valid = 1'b0;
        cnt = 0; par2 = 1'b1;
        while (!tx_ready && cnt < 1000) begin
            if (cnt == 152) par2 = txd;
            @(negedge clk);
            cnt++;
        end
        chk_eq("t2_len2", cnt, 176);
        chk_eq("t2_par1", par1, 0);
        chk_eq("t2_par2", par2, 0);
        repeat (30) @(negedge clk);
        chk_eq("t2_valid1", rx_valid, 1);
        chk_eq("t2_data1", rx_data, 8'h3C);
        pop_word();
        chk_eq("t2_valid2", rx_valid, 1);
        chk_eq("t2_data2", rx_data, 8'hC3);
        pop_word();
        chk_eq("t2_empty", rx_valid, 0);
        chk_eq("t2_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
        lb_sel = 1'b0;

        // 3: 0x01 with even parity but parity bit 0 -> pushed, parity error
        drive_frame({1'b1, 1'b0, 8'h01, 1'b0}, 11);
        chk_eq("t3_valid", rx_valid, 1);
        chk_eq("t3_data", rx_data, 8'h01);
        chk_eq("t3_par_err", rx_parity_err, 1);
        chk_eq("t3_frame_err", rx_frame_err, 0);
        clr_errs();
        chk_eq("t3_par_clr", rx_parity_err, 0);
        pop_word();
        chk_eq("t3_empty", rx_valid, 0);

        // 4: 0x55, no parity, stop bit 0 -> discarded, frame error
        parity_mode = 2'b00;
        drive_frame({1'b0, 8'h55, 1'b0}, 10);
        chk_eq("t4_valid", rx_valid, 0);
        chk_eq("t4_frame_err", rx_frame_err, 1);
        chk_eq("t4_par_err", rx_parity_err, 0);
        clr_errs();
        chk_eq("t4_frame_clr", rx_frame_err, 0);

        // 5: five words into a 4-deep FIFO with no pops -> overrun, first four kept
        for (int i = 0; i < 5; i++) begin
            drive_frame({1'b1, 8'(8'h10 + i), 1'b0}, 10);
            if (i == 3) chk_eq("t5_no_ovr_yet", rx_overrun, 0);
        end
        chk_eq("t5_overrun", rx_overrun, 1);
        for (int i = 0; i < 4; i++) begin
            chk_eq($sformatf("t5_data%0d", i), rx_data, 8'h10 + i);
            chk_eq($sformatf("t5_valid%0d", i), rx_valid, 1);
            pop_word();
        end
        chk_eq("t5_empty", rx_valid, 0);
        clr_errs();

        // 6a: 4-clock low glitch -> false start, nothing happens
        rxd_drv = 1'b0;
        repeat (4) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        chk_eq("t6_glitch_valid", rx_valid, 0);
        chk_eq("t6_glitch_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);

        // 6b: reset in the middle of a TX frame
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk_eq("t6_txd_mid", txd, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("t6_rst_txd", txd, 1);
        chk_eq("t6_rst_ready", tx_ready, 1);
        chk_eq("t6_rst_busy", tx_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
